// File: rtl/aether_cmd_sequencer.sv
// Command queue and issue controller for the aether_engine command port.
// Buffers host commands, issues one per cycle, and for long-running opcodes
// holds NOP until the engine interrupt rises, then issues a status-clear command.
module aether_cmd_sequencer #(
  parameter int unsigned CmdDepth      = 16,
  parameter logic [15:0] WaitMask      = 16'h0000,
  parameter logic [23:0] ClearCmd      = 24'h000000,
  parameter logic [23:0] NopCmd        = 24'h000000,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [23:0]                     cmd_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            flush_i,
  output logic [23:0]                     engine_cmd_o,
  input  logic                            engine_interrupt_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            timeout_o,
  output logic [$clog2(CmdDepth+1)-1:0]   fifo_count_o
);

  localparam int unsigned AddrW = $clog2(CmdDepth);
  localparam int unsigned CntW  = $clog2(CmdDepth + 1);
  localparam int unsigned TmrW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IRQ = 2'd1,
    CLEAR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       cmd_q, cmd_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              irq_q;

  logic [23:0]       mem [CmdDepth];
  logic [AddrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic              empty, full, push, pop, drain, irq_rise;
  logic [23:0]       head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(CmdDepth));
  assign head     = mem[rd_ptr_q];
  assign irq_rise = engine_interrupt_i & ~irq_q;

  assign cmd_ready_o  = ~full & ~flush_i;
  assign push         = cmd_valid_i & cmd_ready_o;
  assign engine_cmd_o = cmd_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign fifo_count_o = count_q;

  // Next-state, issue command, watchdog and queue-control decode
  always_comb begin
    state_d   = state_q;
    cmd_d     = NopCmd;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    drain     = 1'b0;
    if (flush_i) begin
      state_d   = IDLE;
      timeout_d = 1'b0;
      drain     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop   = 1'b1;
            cmd_d = head;
            if (WaitMask[head[23:20]]) begin
              state_d = WAIT_IRQ;
              timer_d = '0;
            end
          end
        end
        WAIT_IRQ: begin
          timer_d = timer_q + TmrW'(1);
          if (irq_rise) begin
            state_d = CLEAR;
          end else if (timer_q == TmrW'(TimeoutCycles - 1)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            drain     = 1'b1;
          end
        end
        CLEAR: begin
          cmd_d   = ClearCmd;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Queue occupancy and busy/done derivation from next-cycle state
  always_comb begin
    count_d = count_q;
    if (drain) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
    busy_d = (count_d != '0) | (state_d != IDLE);
    done_d = busy_q & ~busy_d;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, watchdog timer and interrupt history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q     <= NopCmd;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      irq_q     <= engine_interrupt_i;
    end
  end

  // FIFO pointers and count; a drain drops any same-cycle push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (drain) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
        if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (push && !drain) begin
      mem[wr_ptr_q] <= cmd_i;
    end
  end

endmodule

// File: doc/aether_cmd_sequencer.md
Name: aether_cmd_sequencer

Overview:
- Command queue and issue controller in front of aether_engine's 24-bit command port ({instruction[23:20], param_1[19:16], param_2[15:0]}).
- Buffers host commands and drives exactly one command per cycle, with NopCmd between commands.
- For long-running opcodes (CNV, LDW), holds NOP until the engine interrupt rises, then issues the status-read clear command before continuing.
- Frees the host/CPU from interrupt polling; adds a watchdog timeout.

Parameters:
- CmdDepth, 16: FIFO depth in commands; power of 2, >= 2.
- WaitMask, 16'h0000: bit n set means opcode n (cmd[23:20]) waits for interrupt. Top level sets the CNV and LDW bits from the team constants.
- ClearCmd, 24'h000000: command issued after each interrupt. Top level sets it to {RDR, REG_STATS, 16'h0000}.
- NopCmd, 24'h000000: idle command. Top level sets it to {NOP, 20'h0}.
- TimeoutCycles, 65535: maximum WAIT_IRQ cycles before abort; >= 1.

Ports:
- clk_i  in  1  clock (same clock as engine clk_i)
- rst_ni  in  1  asynchronous active-low reset
- cmd_i  in  24  host command
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  FIFO can accept; push occurs when valid & ready at the edge
- flush_i  in  1  abort queue and any wait
- engine_cmd_o  out  24  registered command to engine instruction_i/param_1_i/param_2_i
- engine_interrupt_i  in  1  engine interrupt_o
- busy_o  out  1  queue non-empty or FSM not IDLE
- done_o  out  1  one-cycle pulse on busy_o falling edge
- timeout_o  out  1  sticky watchdog error; cleared by reset or flush_i
- fifo_count_o  out  $clog2(CmdDepth+1)  queued entries

Behaviour:
- Reset values (async, rst_ni low): engine_cmd_o=NopCmd, FSM=IDLE, FIFO empty, fifo_count_o=0, busy_o=0, done_o=0, timeout_o=0, irq_q=0.
- cmd_ready_o = !full & !flush_i. It is combinational from registered count and flush_i. No bypass: a pop on a full FIFO frees space from the next cycle.
- irq_q registers engine_interrupt_i every cycle. irq_rise = engine_interrupt_i & !irq_q.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty, pop the head and drive engine_cmd_o <= head. If WaitMask[head[23:20]], go to WAIT_IRQ with timer <= 0; otherwise stay in IDLE. If the FIFO is empty, drive NopCmd. Throughput: one non-wait command per cycle back-to-back.
  - WAIT_IRQ: engine_cmd_o <= NopCmd; timer++.
    - On irq_rise, go to CLEAR. A level already high on entry does not release; only a rising edge does.
    - If timer == TimeoutCycles-1 without irq_rise: set timeout_o, empty the FIFO, go to IDLE, issue no ClearCmd.
    - irq_rise on the same cycle as timeout: the interrupt wins and no timeout is flagged.
  - CLEAR: engine_cmd_o <= ClearCmd for exactly one cycle, then go to IDLE. The next queued command appears the following cycle.
- Latency: a command accepted at edge N, with the FIFO empty and FSM in IDLE, is on engine_cmd_o for the single cycle after edge N+1. Interrupt rising before edge M puts ClearCmd on engine_cmd_o after edge M+1 and the next command after edge M+2.
- flush_i (sampled at edge) has highest priority:
  - FIFO emptied; a simultaneous push is dropped.
  - FSM goes to IDLE and engine_cmd_o <= NopCmd.
  - timeout_o cleared; no ClearCmd issued.
- busy_o registered, equal to (next FIFO non-empty) | (next state != IDLE). done_o = 1 for one cycle after busy_o goes from 1 to 0, including after timeout and flush.
- Interrupts arriving outside WAIT_IRQ are ignored, but they still update irq_q.

Test Plan:
- Reset: hold rst_ni=0 mid-WAIT_IRQ with 5 queued. Required: engine_cmd_o=NopCmd, fifo_count_o=0, busy_o=0, timeout_o=0 immediately (async), and no ClearCmd after release.
- Back-to-back: push three WRR commands (0x?1_4002, 0x?2_0004, 0x?3_0040) on consecutive cycles. Required: engine_cmd_o carries each for one cycle on 3 consecutive cycles starting 1 cycle after the first push, then NopCmd. done_o pulses once.
- Wait flow: push CNV then WRR; raise interrupt 50 cycles after CNV issues. Required: CNV for 1 cycle, NopCmd for 50 cycles, ClearCmd for 1 cycle, then WRR.
- Stale interrupt: hold engine_interrupt_i=1 before and while CNV issues, drop it, and re-raise it 10 cycles later. Required: release only after the re-rise, with ClearCmd exactly once.
- Timeout: TimeoutCycles=100, push CNV plus 3 more, no interrupt. Required: timeout_o=1 after 100 WAIT_IRQ cycles, fifo_count_o=0, no ClearCmd, busy_o falls, done_o pulses. A subsequent flush_i clears timeout_o.
- Full/flush: CmdDepth=16, CNV waiting. Push 17: cmd_ready_o=0 at count 16 and the 17th is held. Assert flush_i concurrently with a push: count→0, push dropped, NopCmd, and a later interrupt is ignored.
